// File: rtl/rx_frame_checker.sv
// rtl/rx_frame_checker.sv - UART packet validator with sticky status and FWFT byte FIFO
//
// Purpose: synchronises the receiver's completion strobe, captures the 11-bit
// packet, checks start/stop/parity and queues good data bytes for a
// valid/ready consumer. Sticky error flags and a saturating reject counter
// report what was thrown away.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   packet      [0]=start, [8:1]=data LSB-first, [9]=parity, [10]=stop
//   pkt_done    completion strobe, asynchronous to clk
//   rx_data     FIFO head byte, holds last head while rx_valid=0
//   rx_valid    FIFO non-empty
//   rx_ready    consumer accepts head when rx_valid & rx_ready
//   frame_err   sticky start/stop error
//   parity_err  sticky parity error
//   overrun     sticky: good byte dropped or strobe arrived while busy
//   clr_err     clears the three sticky flags (a same-cycle set wins)
//   reject_cnt  saturating count of rejected packets, cleared by reset only

module rx_frame_checker #(
    parameter int PARITY_MODE = 0,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      packet,
    input  logic             pkt_done,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun,
    input  logic             clr_err,
    output logic [CNT_W-1:0] reject_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_CHECK, S_PUSH} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1, r_s2, r_s3;
    logic             r_v1, r_v2, r_armed;
    logic [10:0]      r_pkt_q;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [7:0]       r_last;
    logic             r_frame_err, r_parity_err, r_overrun;
    logic [CNT_W-1:0] r_reject;

    logic w_rise, w_ferr, w_perr, w_check_bad;
    logic w_full, w_pop, w_push_try, w_wr_ok, w_push;

    // Three-flop synchroniser. The valid pipeline (r_v1/r_v2) marks when s2
    // holds a genuine post-reset sample; rises are only honoured once a low
    // level has been seen, so a strobe held high across reset is ignored
    // until it falls and rises again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_s1 <= pkt_done;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_v1 <= 1'b1;
            r_v2 <= r_v1;
            if (r_v2 && !r_s2)
                r_armed <= 1'b1;
        end
    end

    assign w_rise = r_s2 & ~r_s3 & r_armed;

    assign w_ferr = r_pkt_q[0] | ~r_pkt_q[10];

    always_comb begin
        w_perr = 1'b0;
        if (PARITY_MODE == 0)
            w_perr = ^r_pkt_q[9:1];
        else if (PARITY_MODE == 1)
            w_perr = ~^r_pkt_q[9:1];
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_rise) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_CHECK;
            S_CHECK:   w_state_nxt = (w_ferr | w_perr) ? S_IDLE : S_PUSH;
            S_PUSH:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pkt_q <= '0;
        else if (r_state == S_CAPTURE)
            r_pkt_q <= packet;
    end

    assign w_check_bad = (r_state == S_CHECK) & (w_ferr | w_perr);
    assign w_full      = (r_count == DEPTH_V);
    assign w_pop       = rx_valid & rx_ready;
    assign w_push_try  = (r_state == S_PUSH);
    // A full FIFO still accepts when the consumer frees the head this cycle.
    assign w_wr_ok     = ~w_full | w_pop;
    assign w_push      = w_push_try & w_wr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_reject     <= '0;
        end else begin
            if (w_check_bad && w_ferr)
                r_frame_err <= 1'b1;
            else if (clr_err)
                r_frame_err <= 1'b0;

            if (w_check_bad && w_perr)
                r_parity_err <= 1'b1;
            else if (clr_err)
                r_parity_err <= 1'b0;

            if ((w_push_try && !w_wr_ok) || (w_rise && r_state != S_IDLE))
                r_overrun <= 1'b1;
            else if (clr_err)
                r_overrun <= 1'b0;

            if (w_check_bad && (r_reject != '1))
                r_reject <= r_reject + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_pkt_q[8:1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Remember the head so rx_data does not expose a stale slot once
            // the FIFO drains.
            if (rx_valid)
                r_last <= r_mem[r_rd_ptr];
        end
    end

    assign rx_valid   = (r_count != '0);
    assign rx_data    = rx_valid ? r_mem[r_rd_ptr] : r_last;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign reject_cnt = r_reject;

endmodule
